// File: rtl/sync_ram.sv
// Single-port synchronous RAM with a post-reset zero-fill sweep and registered reads.
// Optional SYNC_RAM_PARITY_EN adds a stored even-parity bit per word, parity_err and inject_par_err.
module sync_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned MEM_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
`ifdef SYNC_RAM_PARITY_EN
  input  logic                  inject_par_err,
  output logic                  parity_err,
`endif
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  ready,
  output logic                  addr_err
);

`ifdef SYNC_RAM_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  localparam int unsigned WORD_W = DATA_WIDTH + PAR_W;
  localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // Pointer must also represent MEM_DEPTH, the "sweep done" value.
  localparam int unsigned PTR_W  = $clog2(MEM_DEPTH + 1);

  typedef enum logic {ST_SWEEP, ST_RUN} state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   ptr, ptr_next;

  logic [WORD_W-1:0]  mem [MEM_DEPTH];

  logic               in_range_c;
  logic               req_c;
  logic               rd_fire_c;
  logic               wr_fire_c;
  logic               mem_we_c;
  logic [IDX_W-1:0]   mem_idx_c;
  logic [WORD_W-1:0]  mem_wdata_c;
  logic [WORD_W-1:0]  rd_word_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_SWEEP;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // Next state: one word per cycle, then one extra edge before going ready
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    if (state == ST_SWEEP) begin
      if (ptr == PTR_W'(MEM_DEPTH)) begin
        state_next = ST_RUN;
      end else begin
        ptr_next = ptr + PTR_W'(1);
      end
    end
  end

  // Output decode: access qualification and memory write port steering
  always_comb begin
    in_range_c  = ({1'b0, addr} < (ADDR_WIDTH + 1)'(MEM_DEPTH));
    req_c       = ready & (wr_en | rd_en);
    rd_fire_c   = ready & rd_en & in_range_c;
    wr_fire_c   = ready & wr_en & in_range_c;
    mem_we_c    = 1'b0;
    mem_idx_c   = IDX_W'(addr);
`ifdef SYNC_RAM_PARITY_EN
    mem_wdata_c = {(^data_in) ^ inject_par_err, data_in};
`else
    mem_wdata_c = data_in;
`endif
    if (state == ST_SWEEP) begin
      mem_we_c    = (ptr != PTR_W'(MEM_DEPTH));
      mem_idx_c   = IDX_W'(ptr);
      mem_wdata_c = '0;
    end else begin
      mem_we_c    = wr_fire_c;
    end
    rd_word_c   = mem[IDX_W'(addr)];
  end

  // Storage array; contents are only ever cleared by the sweep
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[mem_idx_c] <= mem_wdata_c;
    end
  end

  // Registered outputs; read samples the old word on a same-address write
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      valid_out  <= 1'b0;
      addr_err   <= 1'b0;
      ready      <= 1'b0;
`ifdef SYNC_RAM_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      ready      <= (state_next == ST_RUN);
      valid_out  <= rd_fire_c;
      addr_err   <= req_c & ~in_range_c;
      if (rd_fire_c) begin
        data_out <= rd_word_c[DATA_WIDTH-1:0];
      end
`ifdef SYNC_RAM_PARITY_EN
      parity_err <= rd_fire_c & (^rd_word_c);
`endif
    end
  end

endmodule

// File: tb/tb_sync_ram.sv
// Bench for sync_ram: two instances (depth 16 and depth 12) share stimulus and are
// compared every cycle against an array-based reference model.
module tb_sync_ram;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] data_in = '0;

  logic [7:0] dout_a, dout_b;
  logic       vld_a, vld_b, rdy_a, rdy_b, err_a, err_b;
  logic [1:0] perr_bits;

`ifdef SYNC_RAM_PARITY_EN
  logic       inject_par_err = 1'b0;
  logic       perr_a, perr_b;
  assign perr_bits = {perr_b, perr_a};
`else
  assign perr_bits = 2'b00;
`endif

  sync_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .MEM_DEPTH(16)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .data_in(data_in),
`ifdef SYNC_RAM_PARITY_EN
    .inject_par_err(inject_par_err), .parity_err(perr_a),
`endif
    .data_out(dout_a), .valid_out(vld_a), .ready(rdy_a), .addr_err(err_a)
  );

  sync_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .MEM_DEPTH(12)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .data_in(data_in),
`ifdef SYNC_RAM_PARITY_EN
    .inject_par_err(inject_par_err), .parity_err(perr_b),
`endif
    .data_out(dout_b), .valid_out(vld_b), .ready(rdy_b), .addr_err(err_b)
  );

  // Observed word per instance: {parity_err, ready, valid_out, addr_err, data_out}
  logic [11:0] obs [2];
  assign obs[0] = {perr_bits[0], rdy_a, vld_a, err_a, dout_a};
  assign obs[1] = {perr_bits[1], rdy_b, vld_b, err_b, dout_b};

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [7:0]  m_mem  [2][16];
  logic [7:0]  e_dout [2];
  logic        e_vld  [2];
  logic        e_rdy  [2];
  logic        e_err  [2];
  int          since  [2];
  logic [11:0] exp_w  [2];

  // Apply one cycle of inputs and advance the reference model across the edge
  task automatic cycle(input logic r, input logic w, input logic rd,
                       input logic [3:0] a, input logic [7:0] d);
    rst = r; wr_en = w; rd_en = rd; addr = a; data_in = d;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      int   depth;
      logic was_ready;
      depth = (k == 0) ? 16 : 12;
      if (r) begin
        e_dout[k] = 8'h00; e_vld[k] = 1'b0; e_err[k] = 1'b0; e_rdy[k] = 1'b0;
        since[k]  = 0;
        for (int j = 0; j < 16; j++) m_mem[k][j] = 8'h00;
      end else begin
        was_ready = e_rdy[k];
        since[k]  = since[k] + 1;
        e_rdy[k]  = (since[k] > depth);
        e_vld[k]  = 1'b0;
        e_err[k]  = 1'b0;
        if (was_ready && (w || rd)) begin
          if (int'(a) >= depth) begin
            e_err[k] = 1'b1;
          end else begin
            if (rd) begin
              e_dout[k] = m_mem[k][a];
              e_vld[k]  = 1'b1;
            end
            if (w) m_mem[k][a] = d;
          end
        end
      end
      exp_w[k] = {1'b0, e_rdy[k], e_vld[k], e_err[k], e_dout[k]};
    end
    #1;
  endtask

  task automatic test_reset;
    cycle(1, 0, 0, 4'd0, 8'h00);
    cycle(1, 0, 0, 4'd0, 8'h00);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (obs[k] !== 12'h000) begin
        miscompares++;
        $display("FAIL reset_state dut%0d: got %h want %h", k, obs[k], 12'h000);
      end
    end
    // 16 cycles not ready on the depth-16 instance, ready on the 17th
    for (int c = 1; c <= 17; c++) begin
      cycle(0, 0, 0, 4'd0, 8'h00);
      vectors++;
      if (rdy_a !== (c == 17)) begin
        miscompares++;
        $display("FAIL sweep_ready cycle %0d: got %b want %b", c, rdy_a, (c == 17));
      end
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs[k] !== exp_w[k]) begin
          miscompares++;
          $display("FAIL sweep dut%0d cycle %0d: got %h want %h", k, c, obs[k], exp_w[k]);
        end
      end
    end
    cycle(0, 0, 1, 4'd5, 8'h00);
    vectors++;
    if ({vld_a, dout_a} !== {1'b1, 8'h00}) begin
      miscompares++;
      $display("FAIL read_after_sweep: got v=%b d=%h want v=1 d=00", vld_a, dout_a);
    end
  endtask

  task automatic test_write_readback;
    logic [3:0] a_seq [5] = '{4'd3, 4'd15, 4'd3, 4'd15, 4'd0};
    logic       w_seq [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       r_seq [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] d_seq [5] = '{8'hA5, 8'h3C, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 5; i++) begin
      cycle(0, w_seq[i], r_seq[i], a_seq[i], d_seq[i]);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs[k] !== exp_w[k]) begin
          miscompares++;
          $display("FAIL write_readback dut%0d step %0d: got %h want %h", k, i, obs[k], exp_w[k]);
        end
      end
    end
  endtask

  task automatic test_same_addr;
    cycle(0, 1, 0, 4'd7, 8'h11);
    cycle(0, 1, 1, 4'd7, 8'h22);
    vectors++;
    if ({vld_a, dout_a} !== {1'b1, 8'h11}) begin
      miscompares++;
      $display("FAIL rbw_old_word: got v=%b d=%h want v=1 d=11", vld_a, dout_a);
    end
    cycle(0, 0, 1, 4'd7, 8'h00);
    vectors++;
    if ({vld_a, dout_a} !== {1'b1, 8'h22}) begin
      miscompares++;
      $display("FAIL rbw_new_word: got v=%b d=%h want v=1 d=22", vld_a, dout_a);
    end
  endtask

  task automatic test_out_of_range;
    cycle(0, 1, 0, 4'd13, 8'hFF);
    vectors++;
    if ({err_b, vld_b} !== 2'b10) begin
      miscompares++;
      $display("FAIL oor_flag: got err=%b vld=%b want err=1 vld=0", err_b, vld_b);
    end
    cycle(0, 0, 0, 4'd0, 8'h00);
    vectors++;
    if (err_b !== 1'b0) begin
      miscompares++;
      $display("FAIL oor_one_cycle: got err=%b want 0", err_b);
    end
    // Back-to-back reads of every in-range word; valid stays high throughout
    for (int i = 0; i < 13; i++) begin
      cycle(0, 0, (i < 12), 4'(i < 12 ? i : 0), 8'h00);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs[k] !== exp_w[k]) begin
          miscompares++;
          $display("FAIL oor_scan dut%0d addr %0d: got %h want %h", k, i, obs[k], exp_w[k]);
        end
      end
    end
  endtask

  task automatic test_sweep_access;
    cycle(1, 0, 0, 4'd0, 8'h00);
    cycle(0, 1, 0, 4'd2, 8'h77);
    for (int i = 0; i < 40 && rdy_a !== 1'b1; i++) begin
      cycle(0, 1, 1, 4'd2, 8'h77);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs[k] !== exp_w[k]) begin
          miscompares++;
          $display("FAIL sweep_access dut%0d: got %h want %h", k, obs[k], exp_w[k]);
        end
      end
    end
    vectors++;
    if (rdy_a !== 1'b1) begin
      miscompares++;
      $display("FAIL sweep_timeout: ready got %b want 1", rdy_a);
    end
    cycle(0, 0, 1, 4'd2, 8'h00);
    vectors++;
    if ({vld_a, dout_a} !== {1'b1, 8'h00}) begin
      miscompares++;
      $display("FAIL sweep_ignored_write: got v=%b d=%h want v=1 d=00", vld_a, dout_a);
    end
  endtask

  task automatic test_reset_mid;
    cycle(0, 1, 0, 4'd1, 8'h55);
    cycle(0, 0, 1, 4'd1, 8'h00);
    cycle(1, 0, 0, 4'd0, 8'h00);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (obs[k] !== 12'h000) begin
        miscompares++;
        $display("FAIL mid_reset dut%0d: got %h want %h", k, obs[k], 12'h000);
      end
    end
    for (int i = 0; i < 17; i++) cycle(0, 0, 0, 4'd0, 8'h00);
    cycle(0, 0, 1, 4'd1, 8'h00);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (obs[k] !== exp_w[k]) begin
        miscompares++;
        $display("FAIL mid_reset_read dut%0d: got %h want %h", k, obs[k], exp_w[k]);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom),
            4'($urandom), 8'($urandom));
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs[k] !== exp_w[k]) begin
          miscompares++;
          $display("FAIL random dut%0d iter %0d: got %h want %h", k, i, obs[k], exp_w[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_same_addr();
    test_out_of_range();
    test_sweep_access();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_ram.md
Name: sync_ram

Overview:
- Single-port synchronous RAM block, wrapped in the team's RAM interface bundle on the DUT side.
- Write and read share one address bus.
- Reads are registered with one cycle of latency.
- After reset, an internal sweep zero-fills the array before the block accepts accesses.
- Out-of-range addresses are flagged and have no side effects.

Parameters:
- DATA_WIDTH, 8, width of each stored word and of data_in/data_out.
- ADDR_WIDTH, 4, width of addr.
- MEM_DEPTH, 16, number of implemented words. Legal range 1..2**ADDR_WIDTH; addresses >= MEM_DEPTH are out of range.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write request, sampled at rising edge.
- rd_en  input  1  read request, sampled at rising edge.
- addr  input  ADDR_WIDTH  word address for read and/or write.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data.
- valid_out  output  1  high for exactly one cycle when data_out holds fresh read data.
- ready  output  1  high when the block accepts requests (init sweep finished).
- addr_err  output  1  registered; high for one cycle after a request to an out-of-range address.

Behaviour:
- Interface: one clock, named clk; reset is synchronous and active-high, named rst. Sampled only at the rising edge of clk.
- While rst=1 at an edge:
  - data_out=0, valid_out=0, addr_err=0, ready=0.
  - Init pointer is set to 0.
- Init sweep:
  - Starts on the first edge with rst=0.
  - Writes 0 to word[ptr] and increments ptr, one word per cycle, for MEM_DEPTH cycles.
  - ready rises on the edge after the last word is written.
  - wr_en/rd_en are ignored while ready=0; no valid_out, no addr_err.
- Reset mid-sweep or mid-operation restarts the whole sequence. Array contents are not otherwise cleared by rst; the sweep clears them.
- Write, when ready=1, wr_en=1 and addr < MEM_DEPTH: mem[addr] <= data_in at that edge.
- Read, when ready=1, rd_en=1 and addr < MEM_DEPTH:
  - data_out <= mem[addr] at that edge, so data is visible after 1 cycle.
  - valid_out <= 1 for that cycle only.
- No read: valid_out <= 0 and data_out holds its last value.
- Simultaneous wr_en=1 and rd_en=1 to the same address: read-before-write. data_out gets the old word; the new word is stored.
- Out of range (addr >= MEM_DEPTH with wr_en or rd_en):
  - No memory change and no valid_out.
  - data_out holds its value.
  - addr_err <= 1 for one cycle; otherwise addr_err <= 0.
- Back-to-back reads every cycle are supported: valid_out stays high continuously.
- No X propagation: every word reads 0 until first written after the sweep.

Optional Feature:
- Macro: SYNC_RAM_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit computed from data_in on write; the sweep writes parity 0.
  - Added output port parity_err (1 bit, reset 0). Asserted with valid_out when the stored parity mismatches the stored data.
  - Added input port inject_par_err (1 bit). When high during a write, the inverted parity is stored, for fault testing.
- When undefined: no parity storage and no parity_err/inject_par_err ports; behaviour is otherwise identical.

Test Plan:
- Reset then wait: rst=1 for 2 cycles, then 0 → ready=0 for 16 cycles, ready=1 on cycle 17. Reading addr 5 then gives data_out=0x00 with valid_out=1 one cycle later.
- Write/readback: write 0xA5 to addr 3 and 0x3C to addr 15, then read 3 and 15 on consecutive cycles → data_out=0xA5 then 0x3C, valid_out high for 2 cycles.
- Same-address read+write: mem[7]=0x11; drive wr_en=rd_en=1, addr=7, data_in=0x22 → data_out=0x11; next read of 7 → 0x22.
- Out-of-range (MEM_DEPTH=12): write 0xFF to addr 13 → addr_err=1 for one cycle, no valid_out; reads of addrs 0..11 are unchanged.
- Access during sweep: wr_en=1, addr 2, data 0x77 issued while ready=0 → ignored; read of addr 2 after ready → 0x00.
- Reset mid-operation: write 0x55 to addr 1, assert rst for 1 cycle → outputs 0, ready drops, sweep reruns; read of addr 1 after ready → 0x00.
